// File: rtl/gate_stim_checker.sv
// LFSR-driven stimulus generator and response checker for a WIDTH-bit AND gate.
// Optional macro GATE_CHK_STOP_ON_ERR_EN ends a run at the first mismatch.
module gate_stim_checker #(
  parameter int          WIDTH       = 64,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [63:0] SEED_A      = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED_B      = 64'hFEDC_BA98_7654_3210
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim_a,
  output logic [WIDTH-1:0] stim_b,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
  logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
  logic [15:0]      vec_idx_q, vec_idx_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      first_q, first_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic             mismatch_q, mismatch_d;
  logic [15:0]      cmp_idx_q, cmp_idx_d;
  logic             last_vec;
  logic             run_entry;

  assign last_vec  = (vec_idx_q == 16'(NUM_VECTORS - 1));
  assign run_entry = ((state_q == IDLE) || (state_q == DONE)) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (last_vec) state_d = FLUSH;
`ifdef GATE_CHK_STOP_ON_ERR_EN
        if (cmp_valid_q && mismatch_q) state_d = DONE;
`endif
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: the compare result of a vector lands one edge after
  // it is driven, and the counters absorb it on the edge after that.
  always_comb begin
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    vec_idx_d   = vec_idx_q;
    err_d       = err_q;
    first_d     = first_q;
    cmp_valid_d = (state_q == RUN);
    mismatch_d  = (dut_out != (lfsr_a_q & lfsr_b_q));
    cmp_idx_d   = vec_idx_q;
    if (run_entry) begin
      lfsr_a_d  = SEED_A[WIDTH-1:0];
      lfsr_b_d  = SEED_B[WIDTH-1:0];
      vec_idx_d = 16'd0;
      err_d     = 16'd0;
      first_d   = 16'hFFFF;
    end else begin
      if ((state_q == RUN) && (state_d == RUN)) begin
        lfsr_a_d  = {lfsr_a_q[62:0], lfsr_a_q[63] ^ lfsr_a_q[62] ^ lfsr_a_q[60] ^ lfsr_a_q[59]};
        lfsr_b_d  = {lfsr_b_q[62:0], lfsr_b_q[63] ^ lfsr_b_q[62] ^ lfsr_b_q[60] ^ lfsr_b_q[59]};
        vec_idx_d = vec_idx_q + 16'd1;
      end
      if (cmp_valid_q && mismatch_q && ((state_q == RUN) || (state_q == FLUSH))) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    first_d = cmp_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a_q    <= '0;
      lfsr_b_q    <= '0;
      vec_idx_q   <= 16'd0;
      err_q       <= 16'd0;
      first_q     <= 16'hFFFF;
      cmp_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      cmp_idx_q   <= 16'd0;
    end else begin
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      vec_idx_q   <= vec_idx_d;
      err_q       <= err_d;
      first_q     <= first_d;
      cmp_valid_q <= cmp_valid_d;
      mismatch_q  <= mismatch_d;
      cmp_idx_q   <= cmp_idx_d;
    end
  end

  // Output logic
  always_comb begin
    busy          = (state_q == RUN) || (state_q == FLUSH);
    done          = (state_q == DONE);
    pass          = (state_q == DONE) && (err_q == 16'd0);
    stim_a        = lfsr_a_q;
    stim_b        = lfsr_b_q;
    err_count     = err_q;
    first_err_idx = first_q;
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: clean, faulty, saturating and reset-abort runs.
module tb_gate_stim_checker;

  localparam logic [63:0] SA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SB = 64'hFEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_big = 1'b0;
  logic [63:0] stim_a, stim_b, dut_out;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic [63:0] stim_a_big, stim_b_big, dut_out_big;
  logic        busy_big, done_big, pass_big;
  logic [15:0] err_big, first_big;

  int          checks = 0;
  int          failures = 0;
  int          fault_mode = 0;
  logic [63:0] va [16];
  logic [63:0] vb [16];

  always #5 clk = ~clk;

  gate_stim_checker #(.NUM_VECTORS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stim_a(stim_a), .stim_b(stim_b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  gate_stim_checker #(.NUM_VECTORS(65535)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_big),
    .stim_a(stim_a_big), .stim_b(stim_b_big), .dut_out(dut_out_big),
    .busy(busy_big), .done(done_big), .pass(pass_big),
    .err_count(err_big), .first_err_idx(first_big)
  );

  // Modelled gate: correct AND, optionally inverted on vector 3 only.
  always_comb begin
    dut_out = stim_a & stim_b;
    if (fault_mode == 1 && stim_a == va[3] && stim_b == vb[3]) dut_out = ~(stim_a & stim_b);
  end
  assign dut_out_big = ~(stim_a_big & stim_b_big);

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim_a"}, stim_a, 64'd0);
    chk({tag, "_stim_b"}, stim_b, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
    chk({tag, "_err"}, {48'd0, err_count}, 64'd0);
    chk({tag, "_first"}, {48'd0, first_err_idx}, 64'hFFFF);
  endtask

  initial begin
    int n;
    va[0] = SA;
    vb[0] = SB;
    for (int i = 1; i < 16; i++) begin
      va[i] = lfsr_next(va[i-1]);
      vb[i] = lfsr_next(vb[i-1]);
    end

    // Reset state
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    $display("txn reset released");

    // Clean run; a start pulse mid-run must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run1_v0_a", stim_a, va[0]);
    chk("run1_v0_b", stim_b, vb[0]);
    chk("run1_busy", {63'd0, busy}, 64'd1);
    for (int i = 1; i < 16; i++) begin
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
      chk("run1_vec_a", stim_a, va[i]);
      chk("run1_vec_b", stim_b, vb[i]);
    end
    tick();
    chk("run1_flush_busy", {63'd0, busy}, 64'd1);
    chk("run1_flush_done", {63'd0, done}, 64'd0);
    chk("run1_flush_hold", stim_a, va[15]);
    tick();
    chk("run1_done", {63'd0, done}, 64'd1);
    chk("run1_busy_low", {63'd0, busy}, 64'd0);
    chk("run1_pass", {63'd0, pass}, 64'd1);
    chk("run1_err", {48'd0, err_count}, 64'd0);
    chk("run1_first", {48'd0, first_err_idx}, 64'hFFFF);
    $display("txn clean run err=%0d first=%h pass=%0b", err_count, first_err_idx, pass);
    tick();
    tick();
    chk("run1_done_hold", {63'd0, done}, 64'd1);
    chk("run1_stim_hold", stim_b, vb[15]);

    // Faulty vector 3, started from DONE
    fault_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run2_v0_a", stim_a, va[0]);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
`ifdef GATE_CHK_STOP_ON_ERR_EN
    chk("run2_latency", 64'(n), 64'd5);
`else
    chk("run2_latency", 64'(n), 64'd17);
`endif
    chk("run2_err", {48'd0, err_count}, 64'd1);
    chk("run2_first", {48'd0, first_err_idx}, 64'd3);
    chk("run2_pass", {63'd0, pass}, 64'd0);
    $display("txn fault run cycles=%0d err=%0d first=%0d", n, err_count, first_err_idx);
    tick();
    chk("run2_err_hold", {48'd0, err_count}, 64'd1);
    chk("run2_first_hold", {48'd0, first_err_idx}, 64'd3);

    // Restart from DONE clears counters
    fault_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run3_err_clr", {48'd0, err_count}, 64'd0);
    chk("run3_first_clr", {48'd0, first_err_idx}, 64'hFFFF);
    chk("run3_busy", {63'd0, busy}, 64'd1);
    chk("run3_v0_b", stim_b, vb[0]);

    // Asynchronous reset at vector 7
    for (int i = 1; i <= 7; i++) tick();
    chk("run3_v7_a", stim_a, va[7]);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    $display("txn mid-run reset applied");
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_no_resume", {63'd0, busy}, 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run4_v0_a", stim_a, SA);
    chk("run4_v0_b", stim_b, SB);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("run4_latency", 64'(n), 64'd17);
    chk("run4_pass", {63'd0, pass}, 64'd1);
    $display("txn run after reset cycles=%0d pass=%0b", n, pass);

    // Saturation: every vector mismatches
    start_big = 1'b1;
    tick();
    start_big = 1'b0;
    chk("big_v0_a", stim_a_big, SA);
    n = 0;
    while (!done_big && n < 70000) begin
      tick();
      n++;
    end
`ifdef GATE_CHK_STOP_ON_ERR_EN
    chk("big_latency", 64'(n), 64'd2);
    chk("big_err", {48'd0, err_big}, 64'd1);
`else
    chk("big_latency", 64'(n), 64'd65536);
    chk("big_err", {48'd0, err_big}, 64'hFFFF);
`endif
    chk("big_first", {48'd0, first_big}, 64'd0);
    chk("big_pass", {63'd0, pass_big}, 64'd0);
    $display("txn saturation run cycles=%0d err=%h first=%0d", n, err_big, first_big);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
